// File: rtl/idu_id_if.sv
// Bus bundle between the decode stage and its neighbours (IF stage register,
// RTU flush/stall sources, and the EX stage consuming the ID/EX register).
interface idu_id_if;
  // Valid-only transfer, no ready: the decode stage accepts inst/inst_pc
  // whenever inst_vld=1 on an edge without y_stall_ctrl or rtu_global_flush.
  // Stall backpressure is global rather than a per-link ready.
  logic        rtu_global_flush;
  logic [63:0] rtu_flush_pc;
  logic        y_stall_ctrl;
  logic        inst_vld;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic [63:0] idu_ifu_if_pc;
  logic        idu_ex_vld;
  logic [63:0] idu_ex_pc;
  logic [3:0]  idu_ex_op_class;
  logic [4:0]  idu_ex_rd;
  logic [4:0]  idu_ex_rs1;
  logic [4:0]  idu_ex_rs2;
  logic [2:0]  idu_ex_funct3;
  logic        idu_ex_funct7b5;
  logic [63:0] idu_ex_imm;
  logic        idu_ex_illegal;
  logic        idu_dbg_kill;

  modport master (
    output rtu_global_flush, rtu_flush_pc, y_stall_ctrl, inst_vld, inst_pc, inst,
    input  idu_ifu_if_pc, idu_ex_vld, idu_ex_pc, idu_ex_op_class, idu_ex_rd,
           idu_ex_rs1, idu_ex_rs2, idu_ex_funct3, idu_ex_funct7b5, idu_ex_imm,
           idu_ex_illegal, idu_dbg_kill
  );

  modport slave (
    input  rtu_global_flush, rtu_flush_pc, y_stall_ctrl, inst_vld, inst_pc, inst,
    output idu_ifu_if_pc, idu_ex_vld, idu_ex_pc, idu_ex_op_class, idu_ex_rd,
           idu_ex_rs1, idu_ex_rs2, idu_ex_funct3, idu_ex_funct7b5, idu_ex_imm,
           idu_ex_illegal, idu_dbg_kill
  );
endinterface

// File: rtl/idu_id.sv
// RV64I decode stage: owns the fetch PC, registers decoded fields into ID/EX,
// and resolves JAL locally with a one-cycle kill of the wrong-path fetch.
module idu_id #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic     clk,
  input logic     rst_clk,
  idu_id_if.slave bus
);

  typedef enum logic {ST_NORMAL = 1'b0, ST_KILL = 1'b1} state_e;

  localparam logic [3:0] OP_ILLEGAL   = 4'd0;
  localparam logic [3:0] OP_LUI       = 4'd1;
  localparam logic [3:0] OP_AUIPC     = 4'd2;
  localparam logic [3:0] OP_JAL       = 4'd3;
  localparam logic [3:0] OP_JALR      = 4'd4;
  localparam logic [3:0] OP_BRANCH    = 4'd5;
  localparam logic [3:0] OP_LOAD      = 4'd6;
  localparam logic [3:0] OP_STORE     = 4'd7;
  localparam logic [3:0] OP_OP_IMM    = 4'd8;
  localparam logic [3:0] OP_OP        = 4'd9;
  localparam logic [3:0] OP_OP_IMM_32 = 4'd10;
  localparam logic [3:0] OP_OP_32     = 4'd11;
  localparam logic [3:0] OP_FENCE     = 4'd12;
  localparam logic [3:0] OP_SYSTEM    = 4'd13;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        ex_vld_q, ex_vld_d;
  logic [63:0] ex_pc_q, ex_pc_d;
  logic [3:0]  ex_op_q, ex_op_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic [4:0]  ex_rs1_q, ex_rs1_d;
  logic [4:0]  ex_rs2_q, ex_rs2_d;
  logic [2:0]  ex_f3_q, ex_f3_d;
  logic        ex_f7b5_q, ex_f7b5_d;
  logic [63:0] ex_imm_q, ex_imm_d;
  logic        ex_ill_q, ex_ill_d;

  logic [31:0] ins;
  logic [3:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [63:0] dec_imm;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins   = bus.inst;
  assign imm_i = {{52{ins[31]}}, ins[31:20]};
  assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Opcode map; anything outside the RV64I base set (or a compressed
  // encoding) falls through to ILLEGAL.
  always_comb begin
    dec_op = OP_ILLEGAL;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:2])
        5'b01101: dec_op = OP_LUI;
        5'b00101: dec_op = OP_AUIPC;
        5'b11011: dec_op = OP_JAL;
        5'b11001: dec_op = OP_JALR;
        5'b11000: dec_op = OP_BRANCH;
        5'b00000: dec_op = OP_LOAD;
        5'b01000: dec_op = OP_STORE;
        5'b00100: dec_op = OP_OP_IMM;
        5'b01100: dec_op = OP_OP;
        5'b00110: dec_op = OP_OP_IMM_32;
        5'b01110: dec_op = OP_OP_32;
        5'b00011: dec_op = OP_FENCE;
        5'b11100: dec_op = OP_SYSTEM;
        default:  dec_op = OP_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec_imm = 64'd0;
    dec_rd  = ins[11:7];
    case (dec_op)
      OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_SYSTEM, OP_FENCE: dec_imm = imm_i;
      OP_STORE:           begin dec_imm = imm_s; dec_rd = 5'd0; end
      OP_BRANCH:          begin dec_imm = imm_b; dec_rd = 5'd0; end
      OP_LUI, OP_AUIPC:   dec_imm = imm_u;
      OP_JAL:             dec_imm = imm_j;
      OP_ILLEGAL:         dec_rd  = 5'd0;
      default:            dec_imm = 64'd0;
    endcase
  end

  // Flush beats stall beats normal; in KILL the presented fetch is discarded.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ex_vld_d  = ex_vld_q;
    ex_pc_d   = ex_pc_q;
    ex_op_d   = ex_op_q;
    ex_rd_d   = ex_rd_q;
    ex_rs1_d  = ex_rs1_q;
    ex_rs2_d  = ex_rs2_q;
    ex_f3_d   = ex_f3_q;
    ex_f7b5_d = ex_f7b5_q;
    ex_imm_d  = ex_imm_q;
    ex_ill_d  = ex_ill_q;
    if (bus.rtu_global_flush) begin
      state_d   = ST_NORMAL;
      pc_d      = bus.rtu_flush_pc;
      ex_vld_d  = 1'b0;
      ex_pc_d   = 64'd0;
      ex_op_d   = 4'd0;
      ex_rd_d   = 5'd0;
      ex_rs1_d  = 5'd0;
      ex_rs2_d  = 5'd0;
      ex_f3_d   = 3'd0;
      ex_f7b5_d = 1'b0;
      ex_imm_d  = 64'd0;
      ex_ill_d  = 1'b0;
    end else if (!bus.y_stall_ctrl) begin
      if (state_q == ST_NORMAL) begin
        ex_vld_d = bus.inst_vld;
        pc_d     = pc_q + 64'd4;
        if (bus.inst_vld) begin
          ex_pc_d   = bus.inst_pc;
          ex_op_d   = dec_op;
          ex_rd_d   = dec_rd;
          ex_rs1_d  = ins[19:15];
          ex_rs2_d  = ins[24:20];
          ex_f3_d   = ins[14:12];
          ex_f7b5_d = ins[30];
          ex_imm_d  = dec_imm;
          ex_ill_d  = (dec_op == OP_ILLEGAL);
          if (dec_op == OP_JAL) begin
            pc_d    = bus.inst_pc + dec_imm;
            state_d = ST_KILL;
          end
        end
      end else begin
        ex_vld_d = 1'b0;
        pc_d     = pc_q + 64'd4;
        state_d  = ST_NORMAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state_q   <= ST_NORMAL;
      pc_q      <= RESET_PC;
      ex_vld_q  <= 1'b0;
      ex_pc_q   <= 64'd0;
      ex_op_q   <= 4'd0;
      ex_rd_q   <= 5'd0;
      ex_rs1_q  <= 5'd0;
      ex_rs2_q  <= 5'd0;
      ex_f3_q   <= 3'd0;
      ex_f7b5_q <= 1'b0;
      ex_imm_q  <= 64'd0;
      ex_ill_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ex_vld_q  <= ex_vld_d;
      ex_pc_q   <= ex_pc_d;
      ex_op_q   <= ex_op_d;
      ex_rd_q   <= ex_rd_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_f3_q   <= ex_f3_d;
      ex_f7b5_q <= ex_f7b5_d;
      ex_imm_q  <= ex_imm_d;
      ex_ill_q  <= ex_ill_d;
    end
  end

  assign bus.idu_ifu_if_pc   = pc_q;
  assign bus.idu_ex_vld      = ex_vld_q;
  assign bus.idu_ex_pc       = ex_pc_q;
  assign bus.idu_ex_op_class = ex_op_q;
  assign bus.idu_ex_rd       = ex_rd_q;
  assign bus.idu_ex_rs1      = ex_rs1_q;
  assign bus.idu_ex_rs2      = ex_rs2_q;
  assign bus.idu_ex_funct3   = ex_f3_q;
  assign bus.idu_ex_funct7b5 = ex_f7b5_q;
  assign bus.idu_ex_imm      = ex_imm_q;
  assign bus.idu_ex_illegal  = ex_ill_q;
  assign bus.idu_dbg_kill    = (state_q == ST_KILL);

endmodule

// File: doc/idu_id.md
Name: idu_id

Overview:
- Decode stage, directly downstream of the IF stage register; consumes `inst_vld`/`inst_pc`/`inst`.
- Owns the fetch PC register and drives `idu_ifu_if_pc`, the address IF fetches at its next non-stalled edge.
- Decodes RV64I and registers the decoded fields into the ID/EX pipeline register.
- Resolves JAL redirects locally: one-cycle bubble, kills the wrong-path fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC loaded at reset.

Ports:
- clk  in  1  clock, rising edge
- rst_clk  in  1  synchronous reset, active-high
- rtu_global_flush  in  1  pipeline flush from RTU
- rtu_flush_pc  in  64  redirect PC, valid with rtu_global_flush
- y_stall_ctrl  in  1  global stall; hold all state
- inst_vld  in  1  IF output valid
- inst_pc  in  64  PC of inst
- inst  in  32  instruction word
- idu_ifu_if_pc  out  64  next fetch PC (registered)
- idu_ex_vld  out  1  decoded instruction valid
- idu_ex_pc  out  64  PC of decoded instruction
- idu_ex_op_class  out  4  0 ILLEGAL, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 BRANCH, 6 LOAD, 7 STORE, 8 OP_IMM, 9 OP, 10 OP_IMM_32, 11 OP_32, 12 FENCE, 13 SYSTEM
- idu_ex_rd  out  5  destination register
- idu_ex_rs1  out  5  source 1 (inst[19:15])
- idu_ex_rs2  out  5  source 2 (inst[24:20])
- idu_ex_funct3  out  3  inst[14:12]
- idu_ex_funct7b5  out  1  inst[30]
- idu_ex_imm  out  64  sign-extended immediate
- idu_ex_illegal  out  1  illegal-instruction flag

Behaviour:
- All registers are updated on the rising edge of clk only.
- Priority at each edge: rst_clk > rtu_global_flush > y_stall_ctrl > normal.

Reset:
- pc_q=RESET_PC and FSM=NORMAL.
- All idu_ex_* outputs are 0.

Flush:
- pc_q<=rtu_flush_pc and FSM<=NORMAL.
- idu_ex_vld<=0; other idu_ex_* are cleared to 0.
- A JAL present in the same cycle is ignored.

Stall:
- pc_q, FSM and all idu_ex_* hold.

Normal, FSM=NORMAL:
- take = inst_vld.
- idu_ex_vld<=take. When take=1, idu_ex_* load the decode of inst/inst_pc; otherwise the fields hold.
- If take and op_class==JAL: pc_q<=inst_pc+immJ (64-bit, wrap modulo 2^64) and FSM<=KILL.
- Otherwise pc_q<=pc_q+4 (wraps).

Normal, FSM=KILL:
- The instruction presented this cycle is the wrong-path fetch.
- idu_ex_vld<=0, regardless of inst_vld.
- pc_q<=pc_q+4 and FSM<=NORMAL.

Latency:
- inst to idu_ex_*: 1 cycle.
- JAL to first target instruction at ID input: 2 cycles after the JAL is presented (one-bubble penalty).

Decode:
- op_class comes from inst[6:2] when inst[1:0]==2'b11; else ILLEGAL.
- Unknown opcodes are ILLEGAL. idu_ex_illegal = (op_class==ILLEGAL).
- An illegal instruction is still passed with vld=1 and never redirects.
- idu_ex_rd=inst[11:7], forced to 0 for BRANCH, STORE and ILLEGAL.
- Immediate per format, sign-extended to 64 bits:
  - I: LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM, FENCE
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC; {inst[31:12],12'b0} sign-extended from bit 31
  - J: JAL
  - ILLEGAL, OP, OP_32: imm=0
- immB and immJ have bit0=0.

Boundary cases:
- JAL with inst_vld=0: no redirect.
- Stall while FSM=KILL: KILL persists until the first non-stalled edge.
- Flush in KILL: returns to NORMAL with no kill pending.
- Back-to-back JAL: the second JAL arrives in KILL and is dropped as wrong-path.

Test Plan:
- Reset-to-fetch: hold rst_clk high 2 cycles, then release with inst_vld=0. Required: idu_ifu_if_pc=64'h8000_0000, then 64'h8000_0004 next edge, and idu_ex_vld=0.
- Straight-line decode: inst=32'hFFF0_8093 (addi x1,x1,-1), inst_pc=64'h8000_0000. Required next cycle: vld=1, op_class=8, rd=1, rs1=1, imm=64'hFFFF_FFFF_FFFF_FFFF, illegal=0.
- JAL redirect: inst=32'h0100_006F (jal x0,+16) at pc 64'h8000_0008. Required: idu_ifu_if_pc=64'h8000_0018 next cycle; the following instruction (pc 8000_000C) yields idu_ex_vld=0; the target then decodes normally.
- Stall in KILL: JAL as above, then y_stall_ctrl=1 for 3 cycles. Required: idu_ifu_if_pc and idu_ex_* frozen; the first unstalled instruction is still killed.
- Flush priority: JAL presented with rtu_global_flush=1 and rtu_flush_pc=64'h8000_1000. Required: idu_ifu_if_pc=64'h8000_1000, idu_ex_vld=0, no kill next cycle.
- Illegal: inst=32'h0000_0000 with inst_vld=1. Required: vld=1, op_class=0, illegal=1, rd=0, imm=0, PC advances +4.
